// File: rtl/frame_buffer_writer.sv
// Avalon-MM burst write master: packs 32-bit pixels into 64-bit words and writes full bursts to DDR3.
// Optional build macro FRAME_BUFFER_WRITER_FILL_EN adds the solid-colour fill ports.
module frame_buffer_writer #(
  parameter logic [29:0] ADDRESS      = 30'h3800_0000,
  parameter int unsigned LENGTH       = 800*480*4,
  parameter int unsigned BURST_LENGTH = 8,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [31:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  output logic [63:0] writedata,
  output logic [7:0]  byteenable,
  output logic        write,
  input  logic        waitrequest
`ifdef FRAME_BUFFER_WRITER_FILL_EN
  ,
  input  logic        fill,
  input  logic [31:0] fill_color
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int unsigned TOTAL_PIX   = LENGTH / 4;
  localparam int unsigned TOTAL_WORDS = LENGTH / 8;
  localparam int unsigned NUM_BURSTS  = TOTAL_WORDS / BURST_LENGTH;
  localparam int unsigned AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C       = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BURST_C       = CW'(BURST_LENGTH);
  localparam logic [AW-1:0] LAST_PTR      = AW'(FIFO_DEPTH - 1);
  localparam logic [31:0]   TOTAL_PIX_C   = 32'(TOTAL_PIX);
  localparam logic [31:0]   LAST_BURST_C  = 32'(NUM_BURSTS - 1);
  localparam logic [7:0]    BEAT_LAST_C   = 8'(BURST_LENGTH - 1);
  localparam logic [7:0]    BURST_COUNT_C = 8'(BURST_LENGTH);
  localparam logic [28:0]   BASE_WORD_C   = 29'(ADDRESS >> 3);
  localparam logic [28:0]   ADDR_STEP_C   = 29'(BURST_LENGTH);

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic          write_q;
  logic [28:0]   address_q;
  logic [63:0]   writedata_q;
  logic [7:0]    beat_q;
  logic [31:0]   burst_q;
  logic [31:0]   pix_q;
  logic          half_q;
  logic [31:0]   lo_q;
  logic          pend_q;
  logic [63:0]   word_q;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic          start_acc_s;
  logic          room_s;
  logic          pixel_ready_s;
  logic          pix_acc_s;
  logic          beat_s;
  logic          fill_mode_s;
  logic          fill_gen_s;
  logic [63:0]   fill_word_s;
  logic [AW-1:0] wr_ptr_inc_s;
  logic [AW-1:0] rd_ptr_inc_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? {AW{1'b0}} : p + AW'(1);
  endfunction

`ifdef FRAME_BUFFER_WRITER_FILL_EN
  logic        fill_q;
  logic [31:0] color_q;

  // Fill mode and colour are latched with the accepted start and hold for the frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fill_q  <= 1'b0;
      color_q <= 32'd0;
    end else if (start_acc_s) begin
      fill_q  <= fill;
      color_q <= fill_color;
    end
  end

  assign fill_mode_s = fill_q;
  assign fill_word_s = {color_q, color_q};
`else
  assign fill_mode_s = 1'b0;
  assign fill_word_s = 64'd0;
`endif

  assign start_acc_s  = start && (state_q == IDLE);
  assign beat_s       = write_q && !waitrequest;
  assign wr_ptr_inc_s = ptr_inc(wr_ptr_q);
  assign rd_ptr_inc_s = ptr_inc(rd_ptr_q);

  // A word still sitting in the packer counts against FIFO space
  assign room_s        = ({1'b0, count_q} + {{CW{1'b0}}, pend_q}) < {1'b0, DEPTH_C};
  assign pixel_ready_s = busy_q && !fill_mode_s && room_s && (pix_q < TOTAL_PIX_C);
  assign pix_acc_s     = pixel_valid && pixel_ready_s;
  assign fill_gen_s    = busy_q && fill_mode_s && room_s && (pix_q < TOTAL_PIX_C);

  // FIFO occupancy next state from one push and one pop per cycle
  always_comb begin
    count_d = count_q;
    if (pend_q && !beat_s) begin
      count_d = count_q + CW'(1);
    end else if (!pend_q && beat_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pixel packer, pixel counter and FIFO pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_q    <= 32'd0;
      half_q   <= 1'b0;
      lo_q     <= 32'd0;
      pend_q   <= 1'b0;
      word_q   <= 64'd0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (start_acc_s) begin
      pix_q    <= 32'd0;
      half_q   <= 1'b0;
      pend_q   <= 1'b0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      pend_q <= 1'b0;
      if (pix_acc_s) begin
        pix_q <= pix_q + 32'd1;
        if (half_q) begin
          word_q <= {pixel_data, lo_q};
          pend_q <= 1'b1;
          half_q <= 1'b0;
        end else begin
          lo_q   <= pixel_data;
          half_q <= 1'b1;
        end
      end else if (fill_gen_s) begin
        pix_q  <= pix_q + 32'd2;
        word_q <= fill_word_s;
        pend_q <= 1'b1;
      end
      if (pend_q) begin
        wr_ptr_q <= wr_ptr_inc_s;
      end
      if (beat_s) begin
        rd_ptr_q <= rd_ptr_inc_s;
      end
      count_q <= count_d;
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clock) begin
    if (pend_q) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  // Control FSM; every Avalon and status output is a register written here
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= 29'd0;
      writedata_q <= 64'd0;
      beat_q      <= 8'd0;
      burst_q     <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            address_q <= BASE_WORD_C;
            beat_q    <= 8'd0;
            burst_q   <= 32'd0;
            busy_q    <= 1'b1;
            state_q   <= COLLECT;
          end
        end
        COLLECT: begin
          // Only launch once the whole burst is buffered so write never gaps
          if (count_q >= BURST_C) begin
            write_q     <= 1'b1;
            writedata_q <= mem_q[rd_ptr_q];
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (beat_s) begin
            if (beat_q == BEAT_LAST_C) begin
              write_q   <= 1'b0;
              beat_q    <= 8'd0;
              address_q <= address_q + ADDR_STEP_C;
              burst_q   <= burst_q + 32'd1;
              if (burst_q == LAST_BURST_C) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= FINISH;
              end else begin
                state_q <= COLLECT;
              end
            end else begin
              beat_q      <= beat_q + 8'd1;
              writedata_q <= mem_q[rd_ptr_inc_s];
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pixel_ready = pixel_ready_s;
  assign address     = address_q;
  assign burstcount  = BURST_COUNT_C;
  assign writedata   = writedata_q;
  assign byteenable  = 8'hFF;
  assign write       = write_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Self-checking bench for frame_buffer_writer: table of frame scenarios, reset and fill sequences,
// bus monitor and a pixel-list reference model for the expected beats.
module tb_frame_buffer_writer;

  localparam int LEN = 128;
  localparam int BL  = 8;
  localparam int FD  = 16;
  localparam logic [28:0] BASE_W = 29'h0700_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [28:0] address;
  logic [7:0]  burstcount;
  logic [63:0] writedata;
  logic [7:0]  byteenable;
  logic        write;
  logic        waitrequest;
`ifdef FRAME_BUFFER_WRITER_FILL_EN
  logic        fill;
  logic [31:0] fill_color;
`endif

  always #5 clk = ~clk;

  frame_buffer_writer #(
    .ADDRESS      (30'h3800_0000),
    .LENGTH       (LEN),
    .BURST_LENGTH (BL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clock       (clk),
    .reset_n     (reset_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .address     (address),
    .burstcount  (burstcount),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .write       (write),
    .waitrequest (waitrequest)
`ifdef FRAME_BUFFER_WRITER_FILL_EN
    ,
    .fill        (fill),
    .fill_color  (fill_color)
`endif
  );

  typedef struct {
    int          gap;        // idle cycles before each pixel, -1 = random 0..3
    int          wait_pct;
    int          n_offer;
    bit          mid_start;
    bit          rand_data;
    int          exp_acc;
    int          exp_beats;
    bit          chk_first;
    logic [63:0] first_beat;
  } vec_t;

  vec_t        tbl[6];
  int          errors = 0;
  int          checks = 0;
  int          wait_pct = 0;
  bit          abort = 1'b0;
  bit          fill_frame = 1'b0;
  logic [31:0] px[64];

  logic [28:0] q_addr[$];
  logic [7:0]  q_bc[$];
  logic [63:0] q_data[$];
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          cur_beats = 0;
  int          bursts_started = 0;
  logic        prev_write = 1'b0;
  logic        prev_wait = 1'b0;
  logic        prev_busy = 1'b0;
  logic [28:0] prev_addr = 29'd0;
  logic [7:0]  prev_bc = 8'd0;
  logic [63:0] prev_data = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: samples on the falling edge what the next rising edge will accept
  always @(negedge clk) begin
    if (!reset_n) begin
      q_addr.delete(); q_bc.delete(); q_data.delete();
      acc_cnt = 0; done_cnt = 0; cur_beats = 0; bursts_started = 0;
      prev_write = 1'b0; prev_wait = 1'b0; prev_busy = 1'b0;
    end else begin
      if (start && !busy && !done) begin
        q_addr.delete(); q_bc.delete(); q_data.delete();
        acc_cnt = 0; done_cnt = 0; cur_beats = 0; bursts_started = 0;
      end
      if (prev_write && prev_wait) begin
        chk("stall_write", 64'(write), 64'd1);
        chk("stall_addr", 64'(address), 64'(prev_addr));
        chk("stall_bc", 64'(burstcount), 64'(prev_bc));
        chk("stall_data", writedata, prev_data);
      end
      if (write && !prev_write) begin
        if (!fill_frame) chk("write_after_pixels", 64'(acc_cnt >= 2 * BL * (bursts_started + 1)), 64'd1);
        bursts_started++;
      end
      if (!write && prev_write) chk("burst_intact", 64'(cur_beats), 64'd0);
      chk("ready_outside_frame", 64'(pixel_ready && !busy), 64'd0);
      if (fill_frame) chk("fill_ready_low", 64'(pixel_ready), 64'd0);
      if (done) begin
        chk("busy_low_with_done", 64'(busy), 64'd0);
        chk("busy_high_before_done", 64'(prev_busy), 64'd1);
        done_cnt++;
      end
      if (pixel_valid && pixel_ready) acc_cnt++;
      if (write && !waitrequest) begin
        q_addr.push_back(address);
        q_bc.push_back(burstcount);
        q_data.push_back(writedata);
        cur_beats = (cur_beats == BL - 1) ? 0 : cur_beats + 1;
      end
      prev_write = write; prev_wait = waitrequest; prev_busy = busy;
      prev_addr = address; prev_bc = burstcount; prev_data = writedata;
    end
  end

  initial begin
    waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      waitrequest = (wait_pct > 0) && (int'($urandom_range(99)) < wait_pct);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic drive_pixels(input int n, input int gap);
    bit ok;
    int g;
    for (int j = 0; j < n; j++) begin
      if (abort) break;
      g = (gap < 0) ? int'($urandom_range(3)) : gap;
      for (int k = 0; k < g; k++) begin @(posedge clk); #1; end
      pixel_valid = 1'b1;
      pixel_data  = px[j];
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok && !abort; t++) begin
        @(negedge clk); ok = pixel_ready;
        @(posedge clk); #1;
      end
      pixel_valid = 1'b0;
      if (!ok) break;
    end
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_cnt == 0 && t < budget) begin @(posedge clk); t++; end
    #1;
    chk("done_within_budget", 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic fill_px(input bit rnd);
    logic [31:0] r;
    for (int j = 0; j < 64; j++) begin
      r = $urandom();
      px[j] = rnd ? {8'h00, r[23:0]} : 32'(j);
    end
  endtask

  // Expected beats come from the pixel list: word k = {pixel 2k+1, pixel 2k}
  task automatic check_beats(input string tag, input int exp_beats);
    logic [63:0] exp_d;
    logic [28:0] exp_a;
    chk({tag, "_beats"}, 64'(q_data.size()), 64'(exp_beats));
    for (int k = 0; k < exp_beats && k < q_data.size(); k++) begin
      exp_d = {px[2*k+1], px[2*k]};
      exp_a = BASE_W + 29'((k / BL) * BL);
      chk({tag, "_data"}, q_data[k], exp_d);
      chk({tag, "_addr"}, 64'(q_addr[k]), 64'(exp_a));
      chk({tag, "_bc"}, 64'(q_bc[k]), 64'(BL));
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_done"}, 64'(done), 64'd0);
    wait_pct = v.wait_pct;
    fill_px(v.rand_data);
    pulse_start();
    chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
    fork
      drive_pixels(v.n_offer, v.gap);
      begin
        if (v.mid_start) begin
          repeat (20) @(posedge clk);
          #1; start = 1'b1;
          @(posedge clk); #1; start = 1'b0;
        end
      end
    join
    wait_done(4000);
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_accepted"}, 64'(acc_cnt), 64'(v.exp_acc));
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    check_beats(tag, v.exp_beats);
    if (v.chk_first && q_data.size() > 0) chk({tag, "_first_beat"}, q_data[0], v.first_beat);
    wait_pct = 0;
  endtask

  initial begin
    //         gap wait offer mid  rnd  acc beats first  first_beat
    tbl[0] = '{0,   0,  32,  1'b0, 1'b0, 32, 16, 1'b1, 64'h00000001_00000000};
    tbl[1] = '{0,   50, 32,  1'b0, 1'b0, 32, 16, 1'b1, 64'h00000001_00000000};
    tbl[2] = '{4,   0,  32,  1'b0, 1'b1, 32, 16, 1'b0, 64'd0};
    tbl[3] = '{0,   25, 40,  1'b1, 1'b1, 32, 16, 1'b0, 64'd0};
    tbl[4] = '{-1,  30, 32,  1'b0, 1'b1, 32, 16, 1'b0, 64'd0};
    tbl[5] = '{-1,  70, 32,  1'b0, 1'b1, 32, 16, 1'b0, 64'd0};

    reset_n = 1'b0; start = 1'b0; pixel_valid = 1'b0; pixel_data = 32'd0;
`ifdef FRAME_BUFFER_WRITER_FILL_EN
    fill = 1'b0; fill_color = 32'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(pixel_ready), 64'd0);
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chk("rst_bc", 64'(burstcount), 64'(BL));
    chk("rst_data", writedata, 64'd0);
    chk("rst_be", 64'(byteenable), 64'hFF);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < 6; r++) begin
      run_frame(tbl[r], $sformatf("row%0d", r));
      repeat (3) @(posedge clk);
      #1;
    end

    // Reset while beat 3 of the first burst is on the bus
    wait_pct = 0;
    fill_px(1'b0);
    pulse_start();
    fork
      drive_pixels(32, 0);
      begin
        int t = 0;
        while (q_data.size() < 3 && t < 500) begin @(negedge clk); #1; t++; end
        chk("mid_reset_reached", 64'(q_data.size() >= 3), 64'd1);
        chk("mid_reset_write_on", 64'(write), 64'd1);
        reset_n = 1'b0;
        abort   = 1'b1;
        #1;
        chk("mid_reset_write", 64'(write), 64'd0);
        chk("mid_reset_busy", 64'(busy), 64'd0);
        chk("mid_reset_ready", 64'(pixel_ready), 64'd0);
        chk("mid_reset_addr", 64'(address), 64'd0);
      end
    join
    pixel_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    abort   = 1'b0;
    @(posedge clk); #1;
    run_frame(tbl[0], "after_reset");

`ifdef FRAME_BUFFER_WRITER_FILL_EN
    begin
      logic [63:0] fw;
      fw = 64'h00FF0000_00FF0000;
      wait_pct = 20;
      fill_frame = 1'b1;
      pixel_valid = 1'b1;
      pixel_data = 32'h00123456;
      @(posedge clk); #1;
      fill = 1'b1; fill_color = 32'h00FF0000; start = 1'b1;
      @(posedge clk); #1;
      fill = 1'b0; start = 1'b0;
      wait_done(4000);
      repeat (5) @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      fill_frame = 1'b0;
      wait_pct = 0;
      chk("fill_accepted", 64'(acc_cnt), 64'd0);
      chk("fill_done_count", 64'(done_cnt), 64'd1);
      chk("fill_beats", 64'(q_data.size()), 64'(LEN / 8));
      for (int k = 0; k < q_data.size(); k++) begin
        chk("fill_data", q_data[k], fw);
        chk("fill_addr", 64'(q_addr[k]), 64'(BASE_W + 29'((k / BL) * BL)));
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Avalon-MM burst write master that streams 32-bit pixels into the DDR3 frame buffer through the HPS f2h_sdram write port. It is the writing counterpart of the frame buffer scan-out reader: the reader fetches the frame region for the LCD, and this block fills that same region (`ADDRESS`, `LENGTH`) from a pixel stream. It packs pixel pairs into 64-bit words, buffers them in a small FIFO, and issues fixed-length write bursts only when a full burst is buffered.

## Interface
- `ADDRESS`, default 30'h3800_0000: frame buffer base, byte address, 8-byte aligned.
- `LENGTH`, default 800*480*4: frame size in bytes; must be a multiple of 8*`BURST_LENGTH`.
- `BURST_LENGTH`, default 8: 64-bit beats per burst, range 1..128.
- `FIFO_DEPTH`, default 16: 64-bit word FIFO depth; power of two, ≥ `BURST_LENGTH`.
- `clock` input 1: system clock (clock_50 domain).
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a frame write; ignored while `busy`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse after the last beat of the frame is accepted.
- `pixel_data` input 32: pixel {8'h00, R, G, B}.
- `pixel_valid` input 1: `pixel_data` is valid.
- `pixel_ready` output 1: pixel accepted when `pixel_valid && pixel_ready`.
- `address` output 29: Avalon word address (byte address >> 3).
- `burstcount` output 8: always `BURST_LENGTH`.
- `writedata` output 64: beat data.
- `byteenable` output 8: always 8'hFF.
- `write` output 1: Avalon write request.
- `waitrequest` input 1: slave stall.
- `fill` input 1 and `fill_color` input 32: present only with `FRAME_BUFFER_WRITER_FILL_EN`.

## Operation
- States: IDLE, COLLECT, WRITE, FINISH.
- IDLE: on `start`, load the burst address with `ADDRESS>>3`, clear the pixel and beat counters, and empty the packer. Then go to COLLECT.
- Packing: the first pixel of a pair goes to `[31:0]` (lower address) and the second to `[63:32]`. The completed word is pushed to the FIFO in the cycle after the second pixel is accepted.
- `pixel_ready` = `busy` && the FIFO has room for one word, counting a word still in the packer && pixels accepted < `LENGTH/4`. Pixels offered outside a frame or beyond `LENGTH/4` are not accepted.
- COLLECT → WRITE when FIFO occupancy ≥ `BURST_LENGTH`. Because the full burst is buffered first, `write` never drops mid-burst.
- WRITE: `address` and `burstcount` are held constant for the whole burst, and `writedata` is the FIFO head. A beat is transferred when `write && !waitrequest`, which pops the FIFO.
  - After the final beat of a burst, the address advances by `BURST_LENGTH`.
  - If words remain in the frame, go to COLLECT; otherwise go to FINISH.
- FINISH: pulse `done` for one cycle, deassert `busy`, and return to IDLE.
- A `start` arriving in the same cycle as `done` is ignored.
- Reset mid-operation: all outputs go to their reset values immediately, the FIFO and packer are flushed, and the partial frame is abandoned. The Avalon interconnect shares this reset.
- Reset values: `busy`=0, `done`=0, `pixel_ready`=0, `write`=0, `address`=0, `burstcount`=`BURST_LENGTH`, `writedata`=0, `byteenable`=8'hFF.

## Timing
- `start` → `busy` high: 1 cycle. `pixel_ready` may be high in that same cycle.
- FIFO reaches `BURST_LENGTH` words → `write` high on the next cycle.
- With `waitrequest`=0, one beat per cycle, so a burst takes `BURST_LENGTH` cycles.
- There is at least 1 idle cycle between bursts (the WRITE → COLLECT re-check).
- Last beat accepted → `done` high 1 cycle later. `busy` falls in the same cycle as `done`.
- While `waitrequest`=1, `address`, `burstcount`, `writedata` and `write` are held stable.
- All outputs are registered except `pixel_ready`, which is combinational from FIFO occupancy and state.

## Configuration
- Macro `FRAME_BUFFER_WRITER_FILL_EN`.
- Defined: the `fill` and `fill_color` ports exist, and `fill` is sampled with `start`.
  - If `fill`=1, the FIFO is fed internally with {`fill_color`, `fill_color`}, one word per cycle, and `pixel_ready` stays 0 for the whole frame.
  - If `fill`=0, the block behaves as below.
- Undefined: the ports are absent and every frame consumes the pixel stream.

## Test plan
- Pixel-stream ordering:
  - Stimulus: `LENGTH`=128, `BURST_LENGTH`=8. Pulse `start`, then stream pixels 0..31 continuously with `waitrequest`=0.
  - Required response: two bursts at addresses 29'h0700_0000 and 29'h0700_0008, each with `burstcount`=8. First beat is 64'h00000001_00000000. `done` pulses once, and `busy` falls in the same cycle as `done`.
- Backpressure:
  - Stimulus: pseudo-random `waitrequest` at 50%.
  - Required response: `address`, `burstcount` and `writedata` are stable while stalled. Exactly 16 beats in total, data unchanged from the first test.
- Pixel starvation:
  - Stimulus: pixels offered one every 5 cycles.
  - Required response: `write` rises only after 16 pixels, and never deasserts within a burst.
- Overrun and start while busy:
  - Stimulus: 40 pixels offered; a second `start` pulsed mid-frame.
  - Required response: only 32 pixels accepted, `pixel_ready`=0 after pixel 31, and the second `start` has no effect.
- Reset mid-burst:
  - Stimulus: `reset_n` asserted during beat 3 of the first burst.
  - Required response: `write`=0 and `busy`=0 at once. A new `start` then writes from 29'h0700_0000 with clean data.
- Fill mode (`FRAME_BUFFER_WRITER_FILL_EN` defined):
  - Stimulus: `fill`=1, `fill_color`=32'h00FF0000.
  - Required response: all 16 beats are 64'h00FF0000_00FF0000, `pixel_ready` is never 1, and `done` pulses.
